// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard hazard unit for a 5-stage MIPS pipeline with decode-resolved branches.
// Each register holds a countdown of cycles until its in-flight value can be forwarded.
module hazard_scoreboard #(
    parameter int REG_ADDR_W    = 5,
    parameter int ALU_LAT       = 1,
    parameter int LOAD_LAT      = 2,
    parameter int MUL_LAT       = 4,
    parameter int MUL_PIPELINED = 0,
    parameter int PERF_W        = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Branch,
    input  logic                  ID_BranchTaken,
    input  logic                  ID_RegWrite,
    input  logic [REG_ADDR_W-1:0] ID_Rd,
    input  logic                  ID_MemRead,
    input  logic                  ID_MultiCycle,
    output logic                  Stall,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Bubble,
    output logic                  IF_Flush,
    output logic                  MulBusy,
    output logic [PERF_W-1:0]     StallCount
);

    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int CW   = $clog2(MUL_LAT + 1);

    logic [CW-1:0] cnt      [NREG];
    logic [CW-1:0] cnt_next [NREG];
    logic [CW-1:0] busy_cnt;
    logic [CW-1:0] thr;
    logic [CW-1:0] lat;
    logic          rs_haz;
    logic          rt_haz;
    logic          struct_haz;
    logic          hazard_stall;
    logic          issue;

    // Branches compare in decode, so they cannot use EX->EX forwarding and need count 0.
    always_comb begin
        thr          = ID_Branch ? CW'(0) : CW'(1);
        rs_haz       = ID_UsesRs && (ID_Rs != '0) && (cnt[ID_Rs] > thr);
        rt_haz       = ID_UsesRt && (ID_Rt != '0) && (cnt[ID_Rt] > thr);
        struct_haz   = (MUL_PIPELINED == 0) && ID_MultiCycle && (busy_cnt != '0);
        hazard_stall = ID_Valid && (rs_haz || rt_haz || struct_haz);
        issue        = ID_Valid && !hazard_stall;
        if (ID_MultiCycle)
            lat = CW'(MUL_LAT);
        else if (ID_MemRead)
            lat = CW'(LOAD_LAT);
        else
            lat = CW'(ALU_LAT);
    end

    // Taking the max keeps an older, slower producer in charge when a faster one overwrites it.
    always_comb begin
        cnt_next[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_next[r] = (cnt[r] == '0) ? '0 : cnt[r] - 1'b1;
            if (issue && ID_RegWrite && (ID_Rd == REG_ADDR_W'(r)) && (lat > cnt_next[r]))
                cnt_next[r] = lat;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            busy_cnt   <= '0;
            StallCount <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_next[r];
            if ((MUL_PIPELINED == 0) && issue && ID_MultiCycle)
                busy_cnt <= CW'(MUL_LAT - 1);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
            if (hazard_stall && (StallCount != '1))
                StallCount <= StallCount + 1'b1;
        end
    end

    assign Stall        = !Reset && hazard_stall;
    assign PC_Write     = !Stall;
    assign IF_ID_Write  = !Stall;
    assign ID_EX_Bubble = Stall;
    assign IF_Flush     = !Reset && issue && ID_Branch && ID_BranchTaken;
    assign MulBusy      = !Reset && (busy_cnt != '0);

endmodule
